pixel_frame_rx: RTL and testbench

//  Receiving end of the pixel stream (data_in/valid_in, 784 pixels/image, row-major).

---
 rtl/pixel_frame_rx_pkg.sv | 14 +
 rtl/pixel_frame_rx_frame_bank_ram.sv | 33 +++
 rtl/pixel_frame_rx.sv | 91 +++++++++
 tb/tb_pixel_frame_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pixel_frame_rx_pkg.sv
// Shared image geometry and counter widths for the pixel frame receiver and its bench.
package pixel_frame_rx_pkg;
  localparam int unsigned IMG_PIXELS = 784;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned IMG_ADDR_W = 10;
  localparam int unsigned CNT_W      = 16;

  localparam logic [IMG_ADDR_W-1:0] LAST_IDX = IMG_ADDR_W'(IMG_PIXELS - 1);

  // True when a pixel index falls inside one frame.
  function automatic logic in_frame(input logic [IMG_ADDR_W-1:0] idx);
    return idx <= LAST_IDX;
  endfunction
endpackage

// File: rtl/pixel_frame_rx_frame_bank_ram.sv
// Two-bank simple dual-port pixel RAM: one write port, one registered read port.
module pixel_frame_rx_frame_bank_ram
  import pixel_frame_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [IMG_ADDR_W-1:0] wr_idx,
  input  logic [PIX_W-1:0]      wr_data,
  input  logic                  rd_bank,
  input  logic [IMG_ADDR_W-1:0] rd_idx,
  output logic [PIX_W-1:0]      rd_data
);

  logic [PIX_W-1:0] mem [2][IMG_PIXELS];

  always_ff @(posedge clk) begin
    if (wr_en && in_frame(wr_idx)) begin
      mem[wr_bank][wr_idx] <= wr_data;
    end
  end

  // Out-of-frame addresses read as zero rather than whatever the array wraps to.
  always_ff @(posedge clk) begin
    if (rst || !in_frame(rd_idx)) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_bank][rd_idx];
    end
  end

endmodule

// File: rtl/pixel_frame_rx.sv
// Ping-pong frame assembler: streams pixels into one bank while the consumer reads the other.
module pixel_frame_rx
  import pixel_frame_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  frame_valid,
  input  logic [IMG_ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]      rd_data,
  input  logic                  frame_done,
  output logic [CNT_W-1:0]      frame_count,
  output logic [CNT_W-1:0]      drop_count
);

  logic                  wr_bank, rd_bank;
  logic [1:0]            full;
  logic [IMG_ADDR_W-1:0] pix_idx;

  logic                  wr_bank_nxt, rd_bank_nxt;
  logic [1:0]            full_nxt;
  logic [IMG_ADDR_W-1:0] pix_idx_nxt;
  logic [CNT_W-1:0]      frame_count_nxt, drop_count_nxt;
  logic                  accept, last_pix, rel_frame;

  assign ready_out   = ~full[wr_bank];
  assign frame_valid = full[rd_bank];

  // A last-pixel write and a release always target different banks, so both may apply.
  always_comb begin
    accept          = valid_in & ready_out;
    last_pix        = accept && (pix_idx == LAST_IDX);
    rel_frame       = frame_done & frame_valid;
    wr_bank_nxt     = wr_bank;
    rd_bank_nxt     = rd_bank;
    full_nxt        = full;
    pix_idx_nxt     = pix_idx;
    frame_count_nxt = frame_count;
    drop_count_nxt  = drop_count;

    if (accept) begin
      pix_idx_nxt = pix_idx + IMG_ADDR_W'(1);
    end
    if (last_pix) begin
      pix_idx_nxt       = '0;
      full_nxt[wr_bank] = 1'b1;
      wr_bank_nxt       = ~wr_bank;
      frame_count_nxt   = frame_count + CNT_W'(1);
    end
    if (valid_in && !ready_out && (drop_count != '1)) begin
      drop_count_nxt = drop_count + CNT_W'(1);
    end
    if (rel_frame) begin
      full_nxt[rd_bank] = 1'b0;
      rd_bank_nxt       = ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= '0;
      pix_idx     <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      wr_bank     <= wr_bank_nxt;
      rd_bank     <= rd_bank_nxt;
      full        <= full_nxt;
      pix_idx     <= pix_idx_nxt;
      frame_count <= frame_count_nxt;
      drop_count  <= drop_count_nxt;
    end
  end

  pixel_frame_rx_frame_bank_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_idx  (pix_idx),
    .wr_data (data_in),
    .rd_bank (rd_bank),
    .rd_idx  (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_pixel_frame_rx.sv
// Directed bench for pixel_frame_rx: frame assembly, ping-pong handoff, drops and reset.
module tb_pixel_frame_rx;
  import pixel_frame_rx_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [PIX_W-1:0]      data_in;
  logic                  valid_in;
  logic                  ready_out;
  logic                  frame_valid;
  logic [IMG_ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]      rd_data;
  logic                  frame_done;
  logic [CNT_W-1:0]      frame_count;
  logic [CNT_W-1:0]      drop_count;

  int checks   = 0;
  int failures = 0;

  pixel_frame_rx dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .frame_valid (frame_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Per-frame pixel patterns so different frames are distinguishable on readback.
  function automatic logic [PIX_W-1:0] pix_val(input int mode, input int k);
    case (mode)
      1:       return 8'((k * 3 + 7) & 255);
      2:       return 8'((k ^ 32'h5A) & 255);
      default: return 8'(k & 255);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    valid_in   = 1'b0;
    data_in    = '0;
    frame_done = 1'b0;
    rd_addr    = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic stream_pixels(input int mode, input int first, input int n, input bit done_last);
    for (int k = first; k < first + n; k++) begin
      valid_in   = 1'b1;
      data_in    = pix_val(mode, k);
      frame_done = done_last && (k == first + n - 1);
      tick();
    end
    valid_in   = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic read_pix(input int addr, output logic [PIX_W-1:0] d);
    rd_addr = IMG_ADDR_W'(addr);
    tick();
    d = rd_data;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", frame_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_dcnt got=%0d exp=0", drop_count); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rd_data); end
  endtask

  task automatic test_single_frame();
    logic [PIX_W-1:0] d;
    int addrs [3] = '{0, 300, 783};
    logic [7:0] exp_d [3] = '{8'h00, 8'h2C, 8'h0F};
    do_reset();
    stream_pixels(0, 0, 783, 1'b0);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL single_fv_early got=%b exp=0", frame_valid); end
    stream_pixels(0, 783, 1, 1'b0);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL single_fv got=%b exp=1", frame_valid); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL single_fcnt got=%0d exp=1", frame_count); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready_out); end
    for (int i = 0; i < 3; i++) begin
      read_pix(addrs[i], d);
      checks++; if (d !== exp_d[i]) begin failures++; $display("FAIL single_rd[%0d] got=%h exp=%h", addrs[i], d, exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PIX_W-1:0] d;
    do_reset();
    stream_pixels(0, 0, IMG_PIXELS, 1'b0);
    stream_pixels(1, 0, IMG_PIXELS, 1'b0);
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", ready_out); end
    checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL b2b_fcnt2 got=%0d exp=2", frame_count); end
    stream_pixels(2, 0, IMG_PIXELS, 1'b0);
    checks++; if (drop_count !== 16'd784) begin failures++; $display("FAIL b2b_drops got=%0d exp=784", drop_count); end
    checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL b2b_fcnt_after_drop got=%0d exp=2", frame_count); end
    read_pix(10, d);
    checks++; if (d !== pix_val(0, 10)) begin failures++; $display("FAIL b2b_rd_frame1 got=%h exp=%h", d, pix_val(0, 10)); end
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_done got=%b exp=1", ready_out); end
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL b2b_fv_after_done got=%b exp=1", frame_valid); end
    read_pix(10, d);
    checks++; if (d !== pix_val(1, 10)) begin failures++; $display("FAIL b2b_rd_frame2 got=%h exp=%h", d, pix_val(1, 10)); end
  endtask

  task automatic test_done_on_last();
    logic [PIX_W-1:0] d;
    do_reset();
    stream_pixels(0, 0, IMG_PIXELS, 1'b0);
    stream_pixels(2, 0, IMG_PIXELS, 1'b1);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL dol_fv got=%b exp=1", frame_valid); end
    checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL dol_fcnt got=%0d exp=2", frame_count); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL dol_ready got=%b exp=1", ready_out); end
    read_pix(0, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL dol_rd0 got=%h exp=5a", d); end
    read_pix(783, d);
    checks++; if (d !== 8'h55) begin failures++; $display("FAIL dol_rd783 got=%h exp=55", d); end
  endtask

  task automatic test_mid_frame_reset();
    logic [PIX_W-1:0] d;
    do_reset();
    stream_pixels(0, 0, 400, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mrst_ready got=%b exp=1", ready_out); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL mrst_fv got=%b exp=0", frame_valid); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL mrst_fcnt got=%0d exp=0", frame_count); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mrst_rdata got=%h exp=00", rd_data); end
    stream_pixels(1, 0, IMG_PIXELS, 1'b0);
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL mrst_fcnt1 got=%0d exp=1", frame_count); end
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL mrst_fv1 got=%b exp=1", frame_valid); end
    read_pix(0, d);
    checks++; if (d !== pix_val(1, 0)) begin failures++; $display("FAIL mrst_rd0 got=%h exp=%h", d, pix_val(1, 0)); end
    read_pix(399, d);
    checks++; if (d !== pix_val(1, 399)) begin failures++; $display("FAIL mrst_rd399 got=%h exp=%h", d, pix_val(1, 399)); end
  endtask

  task automatic test_gapped_stream();
    logic [PIX_W-1:0] d;
    do_reset();
    rd_addr = IMG_ADDR_W'(900);
    for (int i = 0; i < 1567; i++) begin
      if (i == 1566) begin
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL gap_fv_early got=%b exp=0", frame_valid); end
      end
      valid_in   = (i % 2 == 0);
      data_in    = pix_val(0, i / 2);
      frame_done = (i == 101);
      tick();
    end
    valid_in   = 1'b0;
    frame_done = 1'b0;
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL gap_fv got=%b exp=1", frame_valid); end
    checks++; if (frame_count !== 16'd1) begin failures++; $display("FAIL gap_fcnt got=%0d exp=1", frame_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL gap_dcnt got=%0d exp=0", drop_count); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL gap_rd900 got=%h exp=00", rd_data); end
    read_pix(783, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL gap_rd783 got=%h exp=0f", d); end
    read_pix(400, d);
    checks++; if (d !== 8'h90) begin failures++; $display("FAIL gap_rd400 got=%h exp=90", d); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_done_on_last();
    test_mid_frame_reset();
    test_gapped_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
